// File: rtl/snake_engine.sv
// Snake game engine: variable-length snake with growth, self-collision, scoring
// and a registered per-pixel colour lookup for the VGA path.
module snake_engine #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int TICK_MAX = 10000000,
  parameter int START_X  = 80,
  parameter int START_Y  = 100,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    DIRECTION,
  input  logic [1:0]    MASTER_STATE,
  input  logic [9:0]    ADDRH,
  input  logic [8:0]    ADDRV,
  input  logic [XW-1:0] TARGET_X,
  input  logic [YW-1:0] TARGET_Y,
  output logic [11:0]   COLOUR_OUT,
  output logic          REACHED,
  output logic          COLLIDED,
  output logic [LW-1:0] LENGTH,
  output logic [7:0]    SCORE
);

  localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [1:0]      heading;
  logic [XW-1:0]   seg_x [MAX_LEN];
  logic [YW-1:0]   seg_y [MAX_LEN];
  logic [LW-1:0]   length;
  logic [7:0]      score;
  logic            reached;
  logic            collided;

  logic [1:0]      new_hd;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic            eat;
  logic            hit;

  logic            is_head;
  logic            is_body;
  logic            is_tgt;
  logic [11:0]     colour_p0;
  logic [11:0]     colour_p1;

  assign tick = (tick_cnt == TW'(TICK_MAX - 1));

  // Next head position with reversal suppression and toroidal wrap.
  always_comb begin
    new_hd = DIRECTION;
    if (DIRECTION[1] == heading[1] && DIRECTION[0] != heading[0])
      new_hd = heading;
    nx = seg_x[0];
    ny = seg_y[0];
    case (new_hd)
      2'b00: ny = (seg_y[0] == '0) ? YW'(GRID_H - 1) : seg_y[0] - 1'b1;
      2'b01: ny = (seg_y[0] == YW'(GRID_H - 1)) ? '0 : seg_y[0] + 1'b1;
      2'b10: nx = (seg_x[0] == '0) ? XW'(GRID_W - 1) : seg_x[0] - 1'b1;
      default: nx = (seg_x[0] == XW'(GRID_W - 1)) ? '0 : seg_x[0] + 1'b1;
    endcase
    eat = (nx == TARGET_X) && (ny == TARGET_Y);
  end

  // The tail vacates on a plain move, so it only counts as an obstacle when eating.
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (seg_x[j] == nx && seg_y[j] == ny &&
          ((j < int'(length) - 1) || (eat && j == int'(length) - 1)))
        hit = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt <= '0;
      state    <= S_IDLE;
      heading  <= 2'b11;
      length   <= LW'(INIT_LEN);
      score    <= '0;
      reached  <= 1'b0;
      collided <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(START_X - i);
        seg_y[i] <= YW'(START_Y);
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      reached  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MASTER_STATE == 2'b01)
            state <= S_RUN;
        end
        S_RUN: begin
          if (MASTER_STATE != 2'b01) begin
            state <= S_IDLE;
          end else if (tick) begin
            heading <= new_hd;
            if (hit) begin
              state    <= S_DEAD;
              collided <= 1'b1;
            end else begin
              for (int k = MAX_LEN - 1; k > 0; k--) begin
                seg_x[k] <= seg_x[k-1];
                seg_y[k] <= seg_y[k-1];
              end
              seg_x[0] <= nx;
              seg_y[0] <= ny;
              if (eat) begin
                reached <= 1'b1;
                if (length != LW'(MAX_LEN))
                  length <= length + 1'b1;
                if (score != 8'hFF)
                  score <= score + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Render stage p0: classify the pixel cell being drawn.
  always_comb begin
    is_head = (ADDRH == 10'(seg_x[0])) && (ADDRV == 9'(seg_y[0]));
    is_body = 1'b0;
    for (int j = 1; j < MAX_LEN; j++) begin
      if (j < int'(length) && ADDRH == 10'(seg_x[j]) && ADDRV == 9'(seg_y[j]))
        is_body = 1'b1;
    end
    is_tgt = (ADDRH == 10'(TARGET_X)) && (ADDRV == 9'(TARGET_Y));
    colour_p0 = 12'hAAA;
    if (is_head)
      colour_p0 = (state == S_DEAD) ? 12'hFFF : 12'h0FF;
    else if (is_body)
      colour_p0 = (state == S_DEAD) ? 12'hFFF : 12'h00F;
    else if (is_tgt)
      colour_p0 = 12'hF00;
  end

  // Render stage p1: registered colour.
  always_ff @(posedge CLK) begin
    if (RESET)
      colour_p1 <= 12'hAAA;
    else
      colour_p1 <= colour_p0;
  end

  assign COLOUR_OUT = colour_p1;
  assign REACHED    = reached;
  assign COLLIDED   = collided;
  assign LENGTH     = length;
  assign SCORE      = score;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: two instances (default start and a start
// near the grid edge) stepped one tick at a time and probed through the renderer.
module tb_snake_engine;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  dir_a, ms_a, dir_b, ms_b;
  logic [9:0]  ah_a, ah_b;
  logic [8:0]  av_a, av_b;
  logic [7:0]  tx_a, tx_b;
  logic [6:0]  ty_a, ty_b;
  logic [11:0] col_a, col_b;
  logic        reach_a, reach_b, coll_a, coll_b;
  logic [5:0]  len_a, len_b;
  logic [7:0]  score_a, score_b;

  int tests = 0;
  int fails = 0;
  int ph;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  always #5 CLK = ~CLK;

  snake_engine #(.TICK_MAX(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .DIRECTION(dir_a), .MASTER_STATE(ms_a),
    .ADDRH(ah_a), .ADDRV(av_a), .TARGET_X(tx_a), .TARGET_Y(ty_a),
    .COLOUR_OUT(col_a), .REACHED(reach_a), .COLLIDED(coll_a),
    .LENGTH(len_a), .SCORE(score_a)
  );

  snake_engine #(.TICK_MAX(4), .START_X(158), .START_Y(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .DIRECTION(dir_b), .MASTER_STATE(ms_b),
    .ADDRH(ah_b), .ADDRV(av_b), .TARGET_X(tx_b), .TARGET_Y(ty_b),
    .COLOUR_OUT(col_b), .REACHED(reach_b), .COLLIDED(coll_b),
    .LENGTH(len_b), .SCORE(score_b)
  );

  // Reference phase of the move tick: a step edge is one where ph == 3 beforehand.
  always @(posedge CLK) begin
    if (RESET) ph <= 0;
    else       ph <= (ph == 3) ? 0 : ph + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input bit sel, input int x, input int y,
                       input logic [11:0] exp, input string tag);
    logic [11:0] obs;
    @(negedge CLK);
    if (sel) begin ah_b = 10'(x); av_b = 9'(y); end
    else     begin ah_a = 10'(x); av_a = 9'(y); end
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge CLK);
    obs = sel ? col_b : col_a;
    chk(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
  endtask

  // Enter RUN two edges before a tick edge, take exactly one step, then pause.
  task automatic step(input bit sel, input logic [1:0] d, input logic exp_reach,
                      input string tag);
    @(negedge CLK);
    for (int g = 0; g < 8 && ph != 1; g++) @(negedge CLK);
    chk({tag, "_phase"}, 32'(ph), 32'd1);
    if (sel) begin ms_b = 2'b01; dir_b = d; end
    else     begin ms_a = 2'b01; dir_a = d; end
    repeat (3) @(negedge CLK);
    chk({tag, "_reach"}, 32'(sel ? reach_b : reach_a), 32'(exp_reach));
    if (sel) ms_b = 2'b00;
    else     ms_a = 2'b00;
    @(negedge CLK);
    chk({tag, "_reach_off"}, 32'(sel ? reach_b : reach_a), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_colour", 32'(col_a), 32'h0AAA);
    chk("rst_len", 32'(len_a), 32'd4);
    chk("rst_score", 32'(score_a), 32'd0);
    chk("rst_reach", 32'(reach_a), 32'd0);
    chk("rst_coll", 32'(coll_a), 32'd0);
    chk("rst_len_b", 32'(len_b), 32'd4);
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1;
    dir_a = 2'b11; ms_a = 2'b00; ah_a = '0; av_a = '0; tx_a = 8'd10; ty_a = 7'd10;
    dir_b = 2'b11; ms_b = 2'b00; ah_b = '0; av_b = '0; tx_b = 8'd5;  ty_b = 7'd5;
    do_reset();

    probe(0, 80, 100, 12'h0FF, "head_rst");
    probe(0, 79, 100, 12'h00F, "body_rst");
    probe(0, 77, 100, 12'h00F, "tail_rst");
    probe(0, 76, 100, 12'hAAA, "beyond_len");
    probe(0, 200, 100, 12'hAAA, "off_grid");
    probe(0, 10, 10, 12'hF00, "target");

    step(0, 2'b11, 1'b0, "step1");
    probe(0, 81, 100, 12'h0FF, "head_81");
    probe(0, 77, 100, 12'hAAA, "tail_vacated");
    step(0, 2'b11, 1'b0, "step2");
    probe(0, 82, 100, 12'h0FF, "head_82");
    chk("len_no_eat", 32'(len_a), 32'd4);

    step(0, 2'b10, 1'b0, "reverse");
    probe(0, 83, 100, 12'h0FF, "rev_suppressed");
    step(0, 2'b00, 1'b0, "up");
    probe(0, 83, 99, 12'h0FF, "head_up");
    probe(0, 83, 100, 12'h00F, "neck_up");

    tx_a = 8'd84; ty_a = 7'd99;
    step(0, 2'b11, 1'b1, "eat");
    chk("len_eat", 32'(len_a), 32'd5);
    chk("score_eat", 32'(score_a), 32'd1);
    probe(0, 81, 100, 12'h00F, "tail_kept");
    probe(0, 84, 99, 12'h0FF, "head_over_target");
    tx_a = 8'd10; ty_a = 7'd10;

    step(0, 2'b01, 1'b0, "down");
    probe(0, 84, 100, 12'h0FF, "head_down");
    step(0, 2'b10, 1'b0, "collide");
    chk("coll_set", 32'(coll_a), 32'd1);
    chk("len_dead", 32'(len_a), 32'd5);
    chk("score_dead", 32'(score_a), 32'd1);
    probe(0, 84, 100, 12'hFFF, "dead_head");
    probe(0, 82, 100, 12'hFFF, "dead_body");
    probe(0, 83, 99, 12'hFFF, "dead_body2");
    probe(0, 10, 10, 12'hF00, "dead_target");
    step(0, 2'b11, 1'b0, "dead_step");
    probe(0, 85, 100, 12'hAAA, "dead_frozen");
    probe(0, 84, 100, 12'hFFF, "dead_head2");
    chk("coll_hold", 32'(coll_a), 32'd1);

    do_reset();
    probe(0, 80, 100, 12'h0FF, "head_after_rst");
    probe(0, 84, 100, 12'hAAA, "cleared_after_rst");

    step(1, 2'b11, 1'b0, "b_r1");
    step(1, 2'b11, 1'b0, "b_r2");
    probe(1, 0, 1, 12'h0FF, "wrap_x_hi");
    probe(1, 159, 1, 12'h00F, "wrap_neck");
    step(1, 2'b00, 1'b0, "b_u1");
    step(1, 2'b00, 1'b0, "b_u2");
    probe(1, 0, 119, 12'h0FF, "wrap_y_lo");
    step(1, 2'b11, 1'b0, "b_r3");
    step(1, 2'b01, 1'b0, "b_d1");
    probe(1, 1, 0, 12'h0FF, "wrap_y_hi");
    step(1, 2'b10, 1'b0, "b_l1");
    step(1, 2'b00, 1'b0, "b_tail");
    chk("tail_chase_coll", 32'(coll_b), 32'd0);
    probe(1, 0, 119, 12'h0FF, "tail_chase_head");
    step(1, 2'b10, 1'b0, "b_l2");
    probe(1, 159, 119, 12'h0FF, "wrap_x_lo");
    chk("b_len", 32'(len_b), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor to the fixed-length snake controller. Adds variable length with growth on eating, self-collision detection with a game-over state, reversal suppression, a score counter and a distinct head colour.
- Sits between the direction decoder, the random target generator and the VGA colour path.
- Generates its move tick as a single-cycle enable in the CLK domain; it does not use a derived clock.

Parameters:
- MAX_LEN, 32, segment storage depth; LENGTH saturates here.
- INIT_LEN, 4, length after reset; must satisfy 2 <= INIT_LEN <= MAX_LEN.
- GRID_W, 160, horizontal cells; X wraps at GRID_W-1.
- GRID_H, 120, vertical cells; Y wraps at GRID_H-1.
- XW, 8, X coordinate width.
- YW, 7, Y coordinate width.
- TICK_MAX, 10000000, CLK cycles per move step.
- START_X, 80, reset head X; must satisfy START_X >= INIT_LEN-1.
- START_Y, 100, reset head Y.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- DIRECTION  in  2  requested heading: 00 up, 01 down, 10 left, 11 right.
- MASTER_STATE  in  2  game master state; 01 = play.
- ADDRH  in  10  pixel-cell X being drawn.
- ADDRV  in  9  pixel-cell Y being drawn.
- TARGET_X  in  XW  target X.
- TARGET_Y  in  YW  target Y.
- COLOUR_OUT  out  12  RGB444 for the current ADDRH/ADDRV.
- REACHED  out  1  one-cycle pulse when the target is eaten.
- COLLIDED  out  1  level, high while in DEAD.
- LENGTH  out  clog2(MAX_LEN+1)  current snake length.
- SCORE  out  8  targets eaten; saturates at 255.

Behaviour:
- Reset: all outputs and state are synchronous to CLK.
  - Tick counter = 0; FSM = IDLE; heading = 11.
  - Segment i = (START_X-i, START_Y) for every i; LENGTH = INIT_LEN; SCORE = 0.
  - REACHED = 0; COLLIDED = 0; COLOUR_OUT = 12'hAAA.
- Tick counter: free-runs 0..TICK_MAX-1 in every state. tick = 1 for one cycle when the count is TICK_MAX-1, then the count wraps to 0.
- FSM states and transitions:
  - IDLE -> RUN when MASTER_STATE == 01.
  - RUN -> IDLE when MASTER_STATE != 01; positions are frozen and not reset.
  - RUN -> DEAD on collision.
  - DEAD holds until RESET.
- Step: happens only when tick && state == RUN && MASTER_STATE == 01.
  - Heading update: if DIRECTION is the reverse of the heading (same bit1, different bit0), the heading is kept; otherwise heading <= DIRECTION.
  - next_head = head moved one cell in the new heading.
  - Wrap rules: X 0 -> GRID_W-1 and GRID_W-1 -> 0; Y 0 -> GRID_H-1 and GRID_H-1 -> 0.
  - eat = (next_head == TARGET).
  - Collision = next_head equals segment j for any j in 0..LENGTH-2. When eat is set, j extends to LENGTH-1, because the tail does not vacate.
- On collision:
  - No segment update; state -> DEAD and COLLIDED = 1 from the next cycle.
  - Collision takes priority over eat: no REACHED, no SCORE change.
- Otherwise:
  - Segment[k+1] <= segment[k] for all k; segment[0] <= next_head.
  - If eat: LENGTH += 1 unless already MAX_LEN; SCORE += 1 unless already 255; REACHED = 1 for exactly one cycle (the cycle after the step).
  - Eating at MAX_LEN still scores and pulses REACHED.
- Segments with index >= LENGTH are stored but ignored for collision and rendering.
- Rendering: registered, latency 1 CLK from ADDRH/ADDRV to COLOUR_OUT.
  - Coordinates are zero-extended for compare; ADDRH >= GRID_W or ADDRV >= GRID_H never matches a segment.
  - Priority, highest first:
    - head (segment 0): 12'h0FF, or 12'hFFF in DEAD.
    - body (1..LENGTH-1): 12'h00F, or 12'hFFF in DEAD.
    - target: 12'hF00.
    - background: 12'hAAA.
  - Rendering works in all states, including IDLE.
- RESET mid-step or in DEAD: reset wins and no partial update is kept.

Test Plan:
- TICK_MAX=4, defaults, MASTER_STATE=01, DIRECTION=11 -> head (81,100) after the first tick, (82,100) after the second; LENGTH stays 4; REACHED stays 0.
- Heading right, DIRECTION=10 at a tick -> reversal suppressed, head +1 in X; then DIRECTION=00 -> head Y decrements by 1.
- Head (159,50) moving right -> next (0,50); head (40,0) moving up -> next (40,119).
- TARGET=(81,100), first step -> REACHED high exactly 1 cycle; LENGTH=5; SCORE=1; tail segment unchanged.
- Length 5, turn sequence down, left, up into own body -> COLLIDED=1; state DEAD; positions frozen; body pixels 12'hFFF; RESET clears everything.
- Drive ADDRH=80, ADDRV=100 after reset -> COLOUR_OUT=12'h0FF one cycle later; (79,100) gives 12'h00F; (200,100) gives 12'hAAA.
